// File: rtl/convolution_ls_3x3.sv
// Streaming 3x3 convolution over a raster-scanned 8-bit frame using two line buffers and a 3x3 window.
// Default build uses the Gaussian kernel; define CONV_SHARPEN_EN for the clamped sharpen kernel.
module convolution_ls_3x3 #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 480
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] pixel_i,
  output logic       valid_o,
  output logic [7:0] pixel_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          cap_s;
  logic [CW-1:0] cap_col_s;
  logic [RW-1:0] cap_row_s;
  logic [7:0]    lb_a_q [IMG_W];
  logic [7:0]    lb_b_q [IMG_W];
  logic [7:0]    w_q [3][3];
  logic          win_valid_q;
  logic          sum_valid_q;
  logic [11:0]   sum_d;
  logic [11:0]   sum_q;
  logic [7:0]    pix_d;

  // Position of the pixel captured this cycle; IDLE only captures (0,0) on a frame-start strobe.
  always_comb begin
    cap_s     = 1'b0;
    cap_col_s = col_q;
    cap_row_s = row_q;
    case (state_q)
      IDLE: begin
        cap_s     = valid_i;
        cap_col_s = '0;
        cap_row_s = '0;
      end
      RUN:     cap_s = 1'b1;
      default: cap_s = 1'b0;
    endcase
  end

  // Frame FSM and raster counters; the next position always follows the captured one.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else if (cap_s) begin
      if (cap_col_s == CW'(IMG_W - 1)) begin
        col_q <= '0;
        if (cap_row_s == RW'(IMG_H - 1)) begin
          row_q   <= '0;
          state_q <= IDLE;
        end else begin
          row_q   <= cap_row_s + RW'(1);
          state_q <= RUN;
        end
      end else begin
        col_q   <= cap_col_s + CW'(1);
        row_q   <= cap_row_s;
        state_q <= RUN;
      end
    end
  end

  // Line buffers: lb_a holds the previous row, lb_b the row before it.
  always_ff @(posedge clk_i) begin
    if (cap_s) begin
      lb_a_q[cap_col_s] <= pixel_i;
      lb_b_q[cap_col_s] <= lb_a_q[cap_col_s];
    end
  end

  // Window shift; an output is due only once the window lies fully inside one band of rows.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      win_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          w_q[i][j] <= 8'd0;
        end
      end
    end else begin
      win_valid_q <= cap_s && (cap_row_s >= RW'(2)) && (cap_col_s >= CW'(2));
      if (cap_s) begin
        for (int i = 0; i < 3; i++) begin
          w_q[i][0] <= w_q[i][1];
          w_q[i][1] <= w_q[i][2];
        end
        w_q[0][2] <= lb_b_q[cap_col_s];
        w_q[1][2] <= lb_a_q[cap_col_s];
        w_q[2][2] <= pixel_i;
      end
    end
  end

`ifdef CONV_SHARPEN_EN
  // Sharpen sum in 12-bit two's complement, clamped to the pixel range.
  always_comb begin
    sum_d = 12'(12'd5 * 12'(w_q[1][1]) - 12'(w_q[0][1]) - 12'(w_q[1][0])
                - 12'(w_q[1][2]) - 12'(w_q[2][1]));
    if ($signed(sum_q) < 12'sd0) begin
      pix_d = 8'd0;
    end else if ($signed(sum_q) > 12'sd255) begin
      pix_d = 8'd255;
    end else begin
      pix_d = sum_q[7:0];
    end
  end
`else
  // Gaussian sum (max 16*255 fits 12 bits), normalised by truncating divide by 16.
  always_comb begin
    sum_d = 12'(w_q[0][0]) + 12'(w_q[0][2]) + 12'(w_q[2][0]) + 12'(w_q[2][2])
          + (12'(w_q[0][1]) << 1) + (12'(w_q[1][0]) << 1)
          + (12'(w_q[1][2]) << 1) + (12'(w_q[2][1]) << 1)
          + (12'(w_q[1][1]) << 2);
    pix_d = 8'(sum_q >> 4);
  end
`endif

  // Two-stage output pipeline; pixel_o holds its last value between pulses.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      sum_valid_q <= 1'b0;
      sum_q       <= 12'd0;
      valid_o     <= 1'b0;
      pixel_o     <= 8'd0;
    end else begin
      sum_valid_q <= win_valid_q;
      if (win_valid_q) begin
        sum_q <= sum_d;
      end
      valid_o <= sum_valid_q;
      if (sum_valid_q) begin
        pixel_o <= pix_d;
      end
    end
  end
endmodule

// File: tb/tb_convolution_ls_3x3.sv
// Directed bench for convolution_ls_3x3 on an 8x6 frame; honours CONV_SHARPEN_EN for expected values.
module tb_convolution_ls_3x3;
  localparam int W = 8;
  localparam int H = 6;
  localparam int NOUT = (W - 2) * (H - 2);
`ifdef CONV_SHARPEN_EN
  localparam int IMP = 255;
`else
  localparam int IMP = 160;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] pixel_i = 8'd0;
  logic       valid_o;
  logic [7:0] pixel_o;

  convolution_ls_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .pixel_i(pixel_i),
    .valid_o(valid_o), .pixel_o(pixel_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int out_val[$];
  int out_cyc[$];
  always @(negedge clk_i) begin
    if (valid_o) begin
      out_val.push_back(int'(pixel_o));
      out_cyc.push_back(cyc);
    end
  end

  int tests = 0;
  int fails = 0;
  int start_cyc = 0;
  logic [7:0] img [H][W];

  typedef struct { int value; int exp_count; int exp_pix; } const_vec_t;
  typedef struct { int r; int c; int exp_pix; } probe_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(v);
  endtask

  task automatic clear_out();
    out_val.delete();
    out_cyc.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      pixel_i = 8'(n);
    end
  endtask

  // Drives one frame; optional strobes mid-frame and on the last pixel, optional reset at (rr,rc).
  task automatic feed_frame(input bit repulse, input int rr, input int rc);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        @(negedge clk_i);
        valid_i = (r == 0 && c == 0) ||
                  (repulse && ((r == 2 && c == 5) || (r == H - 1 && c == W - 1)));
        pixel_i = img[r][c];
        if (r == 0 && c == 0) start_cyc = cyc + 1;
        if (r == rr && c == rc) begin
          check("pre_reset_pixel_o", int'(pixel_o), 100);
          rst_ni  = 1'b1;
          valid_i = 1'b0;
          #1;
          check("midframe_reset_valid_o", int'(valid_o), 0);
          check("midframe_reset_pixel_o", int'(pixel_o), 0);
          return;
        end
      end
    end
  endtask

  function automatic int model(input int r, input int c);
    int s;
`ifdef CONV_SHARPEN_EN
    s = 5 * img[r][c] - img[r-1][c] - img[r+1][c] - img[r][c-1] - img[r][c+1];
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
`else
    s = img[r-1][c-1] + img[r-1][c+1] + img[r+1][c-1] + img[r+1][c+1]
      + 2 * (img[r-1][c] + img[r+1][c] + img[r][c-1] + img[r][c+1]) + 4 * img[r][c];
    return s / 16;
`endif
  endfunction

  const_vec_t cvec[3];
  probe_t     probes[5];
  int         errs;

  initial begin
    cvec[0] = '{100, NOUT, 100};
    cvec[1] = '{0,   NOUT, 0};
    cvec[2] = '{255, NOUT, 255};
`ifdef CONV_SHARPEN_EN
    probes[0] = '{2, 2, 255};
    probes[1] = '{1, 2, 0};
    probes[2] = '{1, 1, 0};
    probes[3] = '{3, 3, 0};
    probes[4] = '{4, 4, 0};
`else
    probes[0] = '{2, 2, 40};
    probes[1] = '{1, 2, 20};
    probes[2] = '{1, 1, 10};
    probes[3] = '{3, 3, 10};
    probes[4] = '{4, 4, 0};
`endif

    #1 rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_valid_o", int'(valid_o), 0);
    check("reset_pixel_o", int'(pixel_o), 0);
    rst_ni = 1'b0;

    // Pixels without a frame-start strobe are ignored.
    clear_out();
    drain(60);
    check("idle_no_output", out_val.size(), 0);

    foreach (cvec[i]) begin
      fill_const(cvec[i].value);
      clear_out();
      feed_frame(1'b0, -1, -1);
      drain(10);
      check("const_count", out_val.size(), cvec[i].exp_count);
      errs = 0;
      foreach (out_val[k]) if (out_val[k] != cvec[i].exp_pix) errs++;
      check("const_values_wrong", errs, 0);
      if (out_cyc.size() > 0) check("first_latency", out_cyc[0] - start_cyc, 2 * W + 2 + 2);
      else check("first_latency_missing", 0, 1);
    end

    fill_const(0);
    img[2][2] = 8'(IMP);
    clear_out();
    feed_frame(1'b0, -1, -1);
    drain(10);
    check("impulse_count", out_val.size(), NOUT);
    foreach (probes[i]) begin
      int k;
      k = (probes[i].r - 1) * (W - 2) + (probes[i].c - 1);
      if (k < out_val.size()) check("impulse_probe", out_val[k], probes[i].exp_pix);
      else check("impulse_probe_missing", k, -1);
    end

    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
    clear_out();
    feed_frame(1'b0, -1, -1);
    drain(10);
    check("random_count", out_val.size(), NOUT);
    errs = 0;
    foreach (out_val[k]) if (out_val[k] != model(1 + k / (W - 2), 1 + k % (W - 2))) errs++;
    check("random_vs_model_wrong", errs, 0);

    // Strobes in RUN (including the last pixel) must neither restart nor extend the frame.
    fill_const(100);
    clear_out();
    feed_frame(1'b1, -1, -1);
    drain(40);
    check("repulse_count", out_val.size(), NOUT);
    errs = 0;
    foreach (out_val[k]) if (out_val[k] != 100) errs++;
    check("repulse_values_wrong", errs, 0);

    // Next frame starts on the very first IDLE cycle.
    clear_out();
    feed_frame(1'b0, -1, -1);
    fill_const(50);
    feed_frame(1'b0, -1, -1);
    drain(10);
    check("b2b_count", out_val.size(), 2 * NOUT);
    errs = 0;
    foreach (out_val[k]) if (out_val[k] != ((k < NOUT) ? 100 : 50)) errs++;
    check("b2b_values_wrong", errs, 0);

    fill_const(100);
    feed_frame(1'b0, 3, 4);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    clear_out();
    drain(60);
    check("post_reset_no_output", out_val.size(), 0);
    feed_frame(1'b0, -1, -1);
    drain(10);
    check("post_reset_count", out_val.size(), NOUT);
    errs = 0;
    foreach (out_val[k]) if (out_val[k] != 100) errs++;
    check("post_reset_values_wrong", errs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
